// File: rtl/dual_src_fifo_pkg.sv
// Shared constants and helpers for dual_src_fifo.
// Optional sticky error flags are enabled by defining DUAL_SRC_FIFO_ERR_EN.
package dual_src_fifo_pkg;

   localparam logic SRC_I2 = 1'b0;
   localparam logic SRC_I1 = 1'b1;

   localparam int unsigned PC_W      = 11;
   localparam int unsigned DEPTH_DEF = 4;

   // Pointers are at most 8 bits wide (DEPTH <= 256).
   localparam int unsigned PTR_MAXW  = 8;

   // Wrapping increment: depth-1 -> 0, otherwise +1.
   function automatic logic [PTR_MAXW-1:0] ptr_inc(input logic [PTR_MAXW-1:0] ptr,
                                                   input int unsigned depth);
      if (ptr == PTR_MAXW'(depth - 1)) begin
         return '0;
      end
      return ptr + PTR_MAXW'(1);
   endfunction

endpackage

// File: rtl/dual_src_fifo_if.sv
// Handshake, data and status bundle for dual_src_fifo.
// master = producer/consumer side, slave = the FIFO itself.
interface dual_src_fifo_if
   import dual_src_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = PC_W,
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned CNTW  = $clog2(DEPTH + 1)
);
   logic             flush;
   logic             push;
   logic             pop;
   logic             select;
   logic [WIDTH-1:0] I1;
   logic [WIDTH-1:0] I2;
   logic [WIDTH-1:0] P;
   logic             full;
   logic             empty;
   logic [CNTW-1:0]  count;
   logic             ovf;
   logic             udf;

   modport master (
      output flush, push, pop, select, I1, I2,
      input  P, full, empty, count, ovf, udf
   );

   modport slave (
      input  flush, push, pop, select, I1, I2,
      output P, full, empty, count, ovf, udf
   );
endinterface

// File: rtl/dual_src_fifo_ptr.sv
// fifo_ptr: wrapping pointer over 0..DEPTH-1 with increment and sync clear.
module fifo_ptr
   import dual_src_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned PW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [PW-1:0] ptr_o
);
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   // Next pointer: clear wins over increment.
   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = PW'(ptr_inc(PTR_MAXW'(ptr_q), DEPTH));
      end
   end

   // Pointer register with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;
endmodule

// File: rtl/dual_src_fifo.sv
// dual_src_fifo: show-ahead FIFO pushing one of two sources (I1 PC, I2 field).
// Sticky ovf/udf flags are built only when DUAL_SRC_FIFO_ERR_EN is defined.
module dual_src_fifo
   import dual_src_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = PC_W,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic            clk,
   input  logic            clear_n,
   dual_src_fifo_if.slave  bus
);
   localparam int unsigned CNTW = $clog2(DEPTH + 1);
   localparam int unsigned PW   = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CNTW-1:0]  count_q;
   logic [CNTW-1:0]  count_d;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full_w;
   logic             empty_w;
   logic             push_acc;
   logic             pop_acc;
   logic [WIDTH-1:0] data_in;

   assign full_w   = (count_q == CNTW'(DEPTH));
   assign empty_w  = (count_q == '0);
   // Pop frees a slot the same cycle, so a full FIFO still takes push+pop;
   // an empty FIFO never falls through, so its pop is ignored.
   assign push_acc = bus.push && (!full_w || bus.pop) && !bus.flush;
   assign pop_acc  = bus.pop && !empty_w && !bus.flush;
   assign data_in  = (bus.select == SRC_I1) ? bus.I1 : bus.I2;

   fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
      .clk_i  (clk),
      .rst_ni (clear_n),
      .clr_i  (bus.flush),
      .inc_i  (push_acc),
      .ptr_o  (wr_ptr)
   );

   fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
      .clk_i  (clk),
      .rst_ni (clear_n),
      .clr_i  (bus.flush),
      .inc_i  (pop_acc),
      .ptr_o  (rd_ptr)
   );

   // Storage write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_q[wr_ptr] <= data_in;
      end
   end

   // Occupancy next state: flush empties, otherwise +push -pop.
   always_comb begin
      count_d = count_q;
      if (bus.flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNTW'(push_acc) - CNTW'(pop_acc);
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bus.P     = empty_w ? '0 : mem_q[rd_ptr];
   assign bus.full  = full_w;
   assign bus.empty = empty_w;
   assign bus.count = count_q;

`ifdef DUAL_SRC_FIFO_ERR_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // Sticky flags: set on rejected push / unmasked empty pop, cleared by flush.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (bus.flush) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end else begin
         if (bus.push && full_w && !bus.pop) ovf_d = 1'b1;
         if (bus.pop && empty_w && !bus.push) udf_d = 1'b1;
      end
   end

   // Flag registers.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign bus.ovf = ovf_q;
   assign bus.udf = udf_q;
`else
   assign bus.ovf = 1'b0;
   assign bus.udf = 1'b0;
`endif
endmodule
